mem_wb_stage: RTL and testbench



---
 rtl/mem_wb_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// Pipeline register between the memory stage and writeback. Captures the
// memory read data / ALU result for one instruction per accepted clock edge,
// extracts and extends sub-word loads (big-endian byte lanes), flags
// misaligned loads and suppresses their register write. A sticky error flag
// with the first faulting address and a committed-load counter are kept for
// debug.
//
// Ports:
//   Clock, Reset            rising-edge clock, synchronous active-high reset
//   Stall                   hold every stage register (ErrClear still acts)
//   Flush                   load a bubble instead of the incoming instruction
//   InValid                 incoming instruction is valid
//   RegWriteIn              incoming instruction writes a register
//   MemReadIn               incoming instruction is a load
//   LoadType[2:0]           000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, else LW
//   DestRegIn[4:0]          destination register
//   ALUResult[31:0]         ALU result; [15:0] is the memory address
//   MemData[31:0]           memory read data, same cycle as ALUResult
//   ErrClear                clear the sticky error record
//   OutValid, RegWrite      registered valid / register-file write enable
//   DestReg[4:0]            registered destination register
//   WriteData[31:0]         registered writeback data
//   AddrErr                 registered misalignment flag for this instruction
//   ErrSticky, ErrAddr      sticky misalignment flag and first faulting address
//   LoadCount[CNT_W-1:0]    committed (valid, aligned) loads, wrapping
//
// Handshake: there is no backpressure output. An instruction presented while
// Stall=0 and Flush=0 is taken at that rising edge and appears on the outputs
// right after it, qualified by OutValid; while Stall=1 the outputs hold, and
// Flush turns the slot into a bubble (OutValid=0).
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             InValid,
  input  logic             RegWriteIn,
  input  logic             MemReadIn,
  input  logic [2:0]       LoadType,
  input  logic [4:0]       DestRegIn,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      MemData,
  input  logic             ErrClear,
  output logic             OutValid,
  output logic             RegWrite,
  output logic [4:0]       DestReg,
  output logic [31:0]      WriteData,
  output logic             AddrErr,
  output logic             ErrSticky,
  output logic [15:0]      ErrAddr,
  output logic [CNT_W-1:0] LoadCount
);

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic [1:0]  addr_lo;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        sign_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] sel_data;
  logic        misaligned;
  logic        accept;
  logic        err_set;
  logic        count_inc;

  assign addr_lo = ALUResult[1:0];

  // Unused encodings 101-111 fall into the word class.
  always_comb begin
    is_byte  = 1'b0;
    is_half  = 1'b0;
    sign_ext = 1'b0;
    case (LoadType)
      LT_LB:   begin is_byte = 1'b1; sign_ext = 1'b1; end
      LT_LBU:  begin is_byte = 1'b1; end
      LT_LH:   begin is_half = 1'b1; sign_ext = 1'b1; end
      LT_LHU:  begin is_half = 1'b1; end
      default: begin end
    endcase
  end

  assign is_word = ~is_byte & ~is_half;

  // Big-endian lanes: address offset 0 is the most significant byte.
  always_comb begin
    byte_sel = MemData[31:24];
    case (addr_lo)
      2'd0: byte_sel = MemData[31:24];
      2'd1: byte_sel = MemData[23:16];
      2'd2: byte_sel = MemData[15:8];
      2'd3: byte_sel = MemData[7:0];
      default: byte_sel = MemData[31:24];
    endcase
  end

  assign half_sel = addr_lo[1] ? MemData[15:0] : MemData[31:16];

  always_comb begin
    load_data = MemData;
    if (is_byte) begin
      load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
    end
  end

  assign sel_data = MemReadIn ? load_data : ALUResult;

  // Byte loads can never be misaligned.
  assign misaligned = InValid & MemReadIn &
                      ((is_word & (addr_lo != 2'd0)) | (is_half & addr_lo[0]));

  assign accept    = ~Flush & ~Stall;
  assign err_set   = accept & misaligned;
  assign count_inc = accept & InValid & MemReadIn & ~misaligned;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      OutValid  <= 1'b0;
      RegWrite  <= 1'b0;
      DestReg   <= '0;
      WriteData <= '0;
      AddrErr   <= 1'b0;
      ErrSticky <= 1'b0;
      ErrAddr   <= '0;
      LoadCount <= '0;
    end else if (Flush) begin
      // Bubble: pipeline outputs cleared, debug state untouched.
      OutValid  <= 1'b0;
      RegWrite  <= 1'b0;
      DestReg   <= '0;
      WriteData <= '0;
      AddrErr   <= 1'b0;
    end else begin
      if (!Stall) begin
        OutValid  <= InValid;
        RegWrite  <= InValid & RegWriteIn & ~misaligned;
        DestReg   <= DestRegIn;
        WriteData <= sel_data;
        AddrErr   <= misaligned;
        if (count_inc) begin
          LoadCount <= LoadCount + CNT_W'(1);
        end
      end
      // A new error wins over a clear; the address is reloaded only when the
      // record is empty or being cleared, so the first error is retained.
      if (err_set) begin
        ErrSticky <= 1'b1;
        if (!ErrSticky || ErrClear) begin
          ErrAddr <= ALUResult[15:0];
        end
      end else if (ErrClear) begin
        ErrSticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Directed vectors for mem_wb_stage (CNT_W=4 so the counter wrap is short).
// Each vector carries its hand-computed expected outputs; the driver pushes
// them into exp_q and a separate monitor pops and compares one entry after
// every rising edge.
// Expected vector layout: {OutValid, RegWrite, DestReg, WriteData, AddrErr,
//                          ErrSticky, ErrAddr, LoadCount}
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int CNT_W = 4;
  localparam int W     = 1 + 1 + 5 + 32 + 1 + 1 + 16 + CNT_W;

  localparam logic [2:0] LW  = 3'b000;
  localparam logic [2:0] LB  = 3'b001;
  localparam logic [2:0] LBU = 3'b010;
  localparam logic [2:0] LH  = 3'b011;
  localparam logic [2:0] LHU = 3'b100;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic             Reset;
  logic             Stall;
  logic             Flush;
  logic             InValid;
  logic             RegWriteIn;
  logic             MemReadIn;
  logic [2:0]       LoadType;
  logic [4:0]       DestRegIn;
  logic [31:0]      ALUResult;
  logic [31:0]      MemData;
  logic             ErrClear;
  logic             OutValid;
  logic             RegWrite;
  logic [4:0]       DestReg;
  logic [31:0]      WriteData;
  logic             AddrErr;
  logic             ErrSticky;
  logic [15:0]      ErrAddr;
  logic [CNT_W-1:0] LoadCount;

  mem_wb_stage #(.CNT_W(CNT_W)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Stall      (Stall),
    .Flush      (Flush),
    .InValid    (InValid),
    .RegWriteIn (RegWriteIn),
    .MemReadIn  (MemReadIn),
    .LoadType   (LoadType),
    .DestRegIn  (DestRegIn),
    .ALUResult  (ALUResult),
    .MemData    (MemData),
    .ErrClear   (ErrClear),
    .OutValid   (OutValid),
    .RegWrite   (RegWrite),
    .DestReg    (DestReg),
    .WriteData  (WriteData),
    .AddrErr    (AddrErr),
    .ErrSticky  (ErrSticky),
    .ErrAddr    (ErrAddr),
    .LoadCount  (LoadCount)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           drv_done = 1'b0;

  function automatic logic [W-1:0] pk(
    input logic ov, input logic rw, input logic [4:0] dst,
    input logic [31:0] wd, input logic ae, input logic es,
    input logic [15:0] ea, input logic [CNT_W-1:0] lc);
    return {ov, rw, dst, wd, ae, es, ea, lc};
  endfunction

  // Monitor: one output per edge, compared #1 after the edge.
  always @(posedge Clock) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] got;
      logic [W-1:0] exp_v;
      string        nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      got   = pk(OutValid, RegWrite, DestReg, WriteData, AddrErr,
                 ErrSticky, ErrAddr, LoadCount);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s got ov=%0b rw=%0b dst=%0d wd=%08h ae=%0b es=%0b ea=%04h lc=%0d exp ov=%0b rw=%0b dst=%0d wd=%08h ae=%0b es=%0b ea=%04h lc=%0d",
                 nm, got[W-1], got[W-2], got[W-3 -: 5], got[W-8 -: 32],
                 got[W-40], got[W-41], got[W-42 -: 16], got[CNT_W-1:0],
                 exp_v[W-1], exp_v[W-2], exp_v[W-3 -: 5], exp_v[W-8 -: 32],
                 exp_v[W-40], exp_v[W-41], exp_v[W-42 -: 16], exp_v[CNT_W-1:0]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic vec(
    input string nm, input logic rst, input logic stl, input logic fl,
    input logic iv, input logic rwi, input logic mri, input logic [2:0] lt,
    input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] md,
    input logic clr, input logic [W-1:0] e);
    Reset      = rst;
    Stall      = stl;
    Flush      = fl;
    InValid    = iv;
    RegWriteIn = rwi;
    MemReadIn  = mri;
    LoadType   = lt;
    DestRegIn  = dst;
    ALUResult  = alu;
    MemData    = md;
    ErrClear   = clr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge Clock);
  endtask

  // Valid load with RegWriteIn=1, no stall/flush/clear.
  task automatic ld(input string nm, input logic [2:0] lt, input logic [4:0] dst,
                    input logic [31:0] alu, input logic [31:0] md, input logic [W-1:0] e);
    vec(nm, 0, 0, 0, 1, 1, 1, lt, dst, alu, md, 0, e);
  endtask

  localparam logic [31:0] MD = 32'h80FF7F01;

  initial begin
    // Reset
    vec("reset", 1, 0, 0, 0, 0, 0, LW, 5'd0, 32'h0, 32'h0, 0, pk(0,0,0,32'h0,0,0,16'h0,0));

    // Three loads, then reset mid-stream with a valid load still presented
    ld("ld1", LW, 5'd1, 32'h100, 32'h11111111, pk(1,1,1,32'h11111111,0,0,16'h0,1));
    ld("ld2", LW, 5'd2, 32'h104, 32'h22222222, pk(1,1,2,32'h22222222,0,0,16'h0,2));
    ld("ld3", LW, 5'd3, 32'h108, 32'h33333333, pk(1,1,3,32'h33333333,0,0,16'h0,3));
    vec("reset_mid", 1, 0, 0, 1, 1, 1, LW, 5'd4, 32'h10C, 32'h44444444, 0,
        pk(0,0,0,32'h0,0,0,16'h0,0));

    // Sub-word extraction from 0x80FF7F01
    ld("lb_a0",   LB,  5'd10, 32'h0, MD, pk(1,1,10,32'hFFFFFF80,0,0,16'h0,1));
    ld("lbu_a1",  LBU, 5'd11, 32'h1, MD, pk(1,1,11,32'h000000FF,0,0,16'h0,2));
    ld("lb_a3",   LB,  5'd12, 32'h3, MD, pk(1,1,12,32'h00000001,0,0,16'h0,3));
    ld("lh_a2",   LH,  5'd13, 32'h2, MD, pk(1,1,13,32'h00007F01,0,0,16'h0,4));
    ld("lhu_a0",  LHU, 5'd14, 32'h0, MD, pk(1,1,14,32'h000080FF,0,0,16'h0,5));
    ld("lw_a0",   LW,  5'd15, 32'h0, MD, pk(1,1,15,32'h80FF7F01,0,0,16'h0,6));
    ld("lb_a1",   LB,  5'd16, 32'h1, MD, pk(1,1,16,32'hFFFFFFFF,0,0,16'h0,7));
    ld("lt111_a0", 3'b111, 5'd17, 32'h4, MD, pk(1,1,17,32'h80FF7F01,0,0,16'h0,8));

    // Misalignment: first error address is kept
    ld("mis_lw", LW, 5'd3, 32'h00001236, MD, pk(1,0,3,32'h80FF7F01,1,1,16'h1236,8));
    ld("mis_lh", LH, 5'd4, 32'h00001237, MD, pk(1,0,4,32'h00007F01,1,1,16'h1236,8));
    vec("clr1", 0, 0, 0, 0, 0, 0, LW, 5'd0, 32'h0, 32'h0, 1, pk(0,0,0,32'h0,0,0,16'h1236,8));

    // Set then set-with-clear reloads ErrAddr, later clear alone drops the flag
    ld("mis_lw2", LW, 5'd3, 32'h00001236, MD, pk(1,0,3,32'h80FF7F01,1,1,16'h1236,8));
    vec("mis_lh_clr", 0, 0, 0, 1, 1, 1, LH, 5'd4, 32'h00001237, MD, 1,
        pk(1,0,4,32'h00007F01,1,1,16'h1237,8));
    vec("clr2", 0, 0, 0, 0, 0, 0, LW, 5'd0, 32'h0, 32'h0, 1, pk(0,0,0,32'h0,0,0,16'h1237,8));

    // Non-load ALU op
    vec("alu_op", 0, 0, 0, 1, 1, 0, LW, 5'd5, 32'hDEADBEEF, 32'h12345678, 0,
        pk(1,1,5,32'hDEADBEEF,0,0,16'h1237,8));

    // Stall two cycles with a new load presented: outputs hold
    vec("stall1", 0, 1, 0, 1, 1, 1, LW, 5'd7, 32'h0, 32'h12345678, 0,
        pk(1,1,5,32'hDEADBEEF,0,0,16'h1237,8));
    vec("stall2", 0, 1, 0, 1, 1, 1, LW, 5'd7, 32'h0, 32'h12345678, 0,
        pk(1,1,5,32'hDEADBEEF,0,0,16'h1237,8));
    // Stall + Flush: bubble, counter unchanged
    vec("stall_flush", 0, 1, 1, 1, 1, 1, LW, 5'd7, 32'h0, 32'h12345678, 0,
        pk(0,0,0,32'h0,0,0,16'h1237,8));
    ld("after_stall", LW, 5'd7, 32'h0, 32'h12345678, pk(1,1,7,32'h12345678,0,0,16'h1237,9));

    // ErrClear honoured during stall while everything else holds
    ld("mis_lw3", LW, 5'd2, 32'h00000002, 32'hAAAA5555, pk(1,0,2,32'hAAAA5555,1,1,16'h0002,9));
    vec("stall_clr", 0, 1, 0, 1, 1, 1, LB, 5'd9, 32'h0, 32'h0, 1,
        pk(1,0,2,32'hAAAA5555,1,0,16'h0002,9));
    // Flushed misaligned load leaves sticky state alone
    vec("flush_mis", 0, 0, 1, 1, 1, 1, LW, 5'd9, 32'h00000003, 32'h0, 0,
        pk(0,0,0,32'h0,0,0,16'h0002,9));
    // Invalid load at a misaligned address: no write, no error, no count
    vec("inv_load", 0, 0, 0, 0, 1, 1, LW, 5'd9, 32'h00000003, 32'hCAFEF00D, 0,
        pk(0,0,9,32'hCAFEF00D,0,0,16'h0002,9));
    // Register 0 passes through
    vec("dest0", 0, 0, 0, 1, 1, 0, LW, 5'd0, 32'h00000042, 32'h0, 0,
        pk(1,1,0,32'h00000042,0,0,16'h0002,9));

    // Counter wrap: 16 aligned byte loads after reset
    vec("reset2", 1, 0, 0, 0, 0, 0, LW, 5'd0, 32'h0, 32'h0, 0, pk(0,0,0,32'h0,0,0,16'h0,0));
    for (int i = 0; i < 16; i++) begin
      logic [31:0] wd_e;
      logic [CNT_W-1:0] lc_e;
      wd_e = 32'(i % 4) + 32'd1;
      lc_e = CNT_W'(i + 1);
      ld($sformatf("wrap%0d", i), LBU, 5'd20, 32'(i % 4), 32'h01020304,
         pk(1,1,20,wd_e,0,0,16'h0,lc_e));
    end

    // Idle until the monitor drains the queue (bounded)
    vec("idle", 0, 0, 0, 0, 0, 0, LW, 5'd0, 32'h0, 32'h0, 0, pk(0,0,0,32'h0,0,0,16'h0,0));
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge Clock);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending entries exp 0", exp_q.size());
    end
    drv_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
